// File: rtl/apb_slave_regbank.sv
// APB slave with 16 x 32-bit registers: 0..13 R/W, 14 = write counter, 15 = error counter.
// Define APB_SLV_ERRCHK_EN to enable protocol/range checking, perr and the error counter.
module apb_slave_regbank #(
  parameter int SLV_IDX = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        perr
);

`ifdef APB_SLV_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] regs_q [0:13];
  logic [15:0] wr_cnt_q;
  logic [7:0]  err_cnt_q;
  logic [31:0] prdata_q, prdata_d;
  logic        perr_q, perr_d;

  logic        psel;
  logic [3:0]  idx;
  logic        in_range;
  logic        wr_en;
  logic        load_rd;
  logic [31:0] rd_val;
  logic        unused_addr;

  assign psel        = Pselx[SLV_IDX];
  assign idx         = Paddr[5:2];
  assign in_range    = ERRCHK ? (Paddr[11:6] == 6'd0) : 1'b1;
  assign unused_addr = ^{Paddr[31:12], Paddr[1:0]};

  always_comb begin
    rd_val = 32'd0;
    if (!in_range) begin
      rd_val = 32'hDEAD_BEEF;
    end else begin
      case (idx)
        4'd14:   rd_val = {16'd0, wr_cnt_q};
        4'd15:   rd_val = ERRCHK ? {24'd0, err_cnt_q} : 32'd0;
        default: rd_val = regs_q[idx];
      endcase
    end
  end

  // Prdata defaults to 0; it is only held from SETUP into ACCESS or reloaded by a read SETUP.
  always_comb begin
    state_d  = state_q;
    prdata_d = 32'd0;
    perr_d   = 1'b0;
    wr_en    = 1'b0;
    load_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !Penable) begin
          state_d = ST_SETUP;
          load_rd = !Pwrite;
        end else if (psel && Penable) begin
          perr_d = ERRCHK;
        end
      end
      ST_SETUP: begin
        if (psel && Penable) begin
          state_d  = ST_ACCESS;
          wr_en    = Pwrite && in_range;
          prdata_d = prdata_q;
          perr_d   = ERRCHK && !in_range;
        end else begin
          state_d = ST_IDLE;
          perr_d  = ERRCHK;
        end
      end
      ST_ACCESS: begin
        if (psel && !Penable) begin
          state_d = ST_SETUP;
          load_rd = !Pwrite;
        end else if (psel && Penable) begin
          state_d = ST_IDLE;
          perr_d  = ERRCHK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_rd) prdata_d = rd_val;
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      prdata_q  <= 32'd0;
      perr_q    <= 1'b0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 8'd0;
      for (int i = 0; i < 14; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
      perr_q   <= perr_d;
      if (wr_en && idx < 4'd14) begin
        regs_q[idx] <= Pwdata;
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      // Clear takes priority over a simultaneous error increment.
      if (wr_en && idx == 4'd15) begin
        err_cnt_q <= 8'd0;
      end else if (perr_d && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign Prdata = prdata_q;
  assign perr   = perr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed self-checking bench for apb_slave_regbank; expectations follow APB_SLV_ERRCHK_EN.
module tb_apb_slave_regbank;

`ifdef APB_SLV_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif
  localparam int SLV = 1;
  localparam logic [2:0] SEL   = 3'b010;
  localparam logic [2:0] OTHER = 3'b101;

  logic        clk;
  logic        rst_n;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        perr;

  int tests_run;
  int tests_failed;

  apb_slave_regbank #(.SLV_IDX(SLV)) dut (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .perr(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full SETUP+ACCESS transfer starting at a negedge; samples in the ACCESS cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rd, output logic pe);
    Pselx = SEL; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    @(negedge clk);
    Penable = 1'b1;
    @(negedge clk);
    rd = Prdata;
    pe = perr;
  endtask

  task automatic go_idle();
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    go_idle();
    go_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic pe;
    reset_dut();
    tests_run++;
    if (Prdata !== 32'd0) begin tests_failed++; $display("FAIL reset_prdata got %h exp %h", Prdata, 32'd0); end
    tests_run++;
    if (perr !== 1'b0) begin tests_failed++; $display("FAIL reset_perr got %b exp 0", perr); end
    xfer(1'b0, 32'h38, 32'd0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_reg14 got %h exp %h", rd, 32'd0); end
    xfer(1'b0, 32'h3C, 32'd0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL reset_reg15 got %h exp %h", rd, 32'd0); end
    go_idle();
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic pe;
    reset_dut();
    xfer(1'b1, 32'h8000_0008, 32'hA5A5_1234, rd, pe);
    tests_run++;
    if (pe !== 1'b0) begin tests_failed++; $display("FAIL basic_wr_perr got %b exp 0", pe); end
    go_idle();
    xfer(1'b0, 32'h8000_0008, 32'd0, rd, pe);
    tests_run++;
    if (rd !== 32'hA5A5_1234) begin tests_failed++; $display("FAIL basic_rd got %h exp %h", rd, 32'hA5A5_1234); end
    tests_run++;
    if (pe !== 1'b0) begin tests_failed++; $display("FAIL basic_rd_perr got %b exp 0", pe); end
    go_idle();
    tests_run++;
    if (Prdata !== 32'd0) begin tests_failed++; $display("FAIL basic_prdata_clear got %h exp %h", Prdata, 32'd0); end
    xfer(1'b0, 32'h38, 32'd0, rd, pe);
    tests_run++;
    if (rd !== 32'd1) begin tests_failed++; $display("FAIL basic_reg14 got %h exp %h", rd, 32'd1); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic pe;
    reset_dut();
    xfer(1'b1, 32'h00, 32'h1, rd, pe);
    xfer(1'b1, 32'h04, 32'h2, rd, pe);
    xfer(1'b0, 32'h00, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'h1) begin tests_failed++; $display("FAIL b2b_rd0 got %h exp %h", rd, 32'h1); end
    xfer(1'b0, 32'h04, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'h2) begin tests_failed++; $display("FAIL b2b_rd1 got %h exp %h", rd, 32'h2); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd2) begin tests_failed++; $display("FAIL b2b_reg14 got %h exp %h", rd, 32'd2); end
    go_idle();
    tests_run++;
    if (Prdata !== 32'd0) begin tests_failed++; $display("FAIL b2b_prdata_clear got %h exp %h", Prdata, 32'd0); end
  endtask

  task automatic test_penable_hold();
    logic [31:0] rd; logic pe;
    reset_dut();
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h3333_0003;
    @(negedge clk);
    Penable = 1'b1;
    @(negedge clk);
    tests_run++;
    if (perr !== 1'b0) begin tests_failed++; $display("FAIL hold_access_perr got %b exp 0", perr); end
    Pwdata = 32'h4444_0004;
    @(negedge clk);
    tests_run++;
    if (perr !== ERRCHK) begin tests_failed++; $display("FAIL hold_perr got %b exp %b", perr, ERRCHK); end
    go_idle();
    tests_run++;
    if (perr !== 1'b0) begin tests_failed++; $display("FAIL hold_perr_pulse got %b exp 0", perr); end
    xfer(1'b0, 32'h0C, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'h3333_0003) begin tests_failed++; $display("FAIL hold_reg3 got %h exp %h", rd, 32'h3333_0003); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd1) begin tests_failed++; $display("FAIL hold_reg14 got %h exp %h", rd, 32'd1); end
    xfer(1'b0, 32'h3C, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'd1 : 32'd0)) begin tests_failed++; $display("FAIL hold_reg15 got %h exp %h", rd, ERRCHK ? 32'd1 : 32'd0); end
    xfer(1'b1, 32'h3C, 32'hFFFF_FFFF, rd, pe);
    xfer(1'b0, 32'h3C, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL hold_reg15_clr got %h exp %h", rd, 32'd0); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd1) begin tests_failed++; $display("FAIL hold_reg14_after_clr got %h exp %h", rd, 32'd1); end
    go_idle();
  endtask

  task automatic test_range();
    logic [31:0] rd; logic pe;
    reset_dut();
    xfer(1'b1, 32'h00, 32'h1111_2222, rd, pe);
    go_idle();
    xfer(1'b0, 32'h8000_0040, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'hDEAD_BEEF : 32'h1111_2222)) begin tests_failed++; $display("FAIL range_rd got %h exp %h", rd, ERRCHK ? 32'hDEAD_BEEF : 32'h1111_2222); end
    tests_run++;
    if (pe !== ERRCHK) begin tests_failed++; $display("FAIL range_rd_perr got %b exp %b", pe, ERRCHK); end
    xfer(1'b1, 32'h8000_0040, 32'h99, rd, pe);
    tests_run++;
    if (pe !== ERRCHK) begin tests_failed++; $display("FAIL range_wr_perr got %b exp %b", pe, ERRCHK); end
    go_idle();
    xfer(1'b0, 32'h00, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'h1111_2222 : 32'h99)) begin tests_failed++; $display("FAIL range_reg0 got %h exp %h", rd, ERRCHK ? 32'h1111_2222 : 32'h99); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'd1 : 32'd2)) begin tests_failed++; $display("FAIL range_reg14 got %h exp %h", rd, ERRCHK ? 32'd1 : 32'd2); end
    xfer(1'b0, 32'h3C, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'd2 : 32'd0)) begin tests_failed++; $display("FAIL range_reg15 got %h exp %h", rd, ERRCHK ? 32'd2 : 32'd0); end
    go_idle();
  endtask

  task automatic test_proto_err();
    logic [31:0] rd; logic pe;
    reset_dut();
    Pselx = SEL; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'hABC;
    @(negedge clk);
    tests_run++;
    if (perr !== ERRCHK) begin tests_failed++; $display("FAIL proto_idle_en got %b exp %b", perr, ERRCHK); end
    go_idle();
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'hABC;
    @(negedge clk);
    Pselx = 3'b000;
    @(negedge clk);
    tests_run++;
    if (perr !== ERRCHK) begin tests_failed++; $display("FAIL proto_setup_abort got %b exp %b", perr, ERRCHK); end
    go_idle();
    xfer(1'b0, 32'h14, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL proto_reg5 got %h exp %h", rd, 32'd0); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL proto_reg14 got %h exp %h", rd, 32'd0); end
    xfer(1'b0, 32'h3C, 32'h0, rd, pe);
    tests_run++;
    if (rd !== (ERRCHK ? 32'd2 : 32'd0)) begin tests_failed++; $display("FAIL proto_reg15 got %h exp %h", rd, ERRCHK ? 32'd2 : 32'd0); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic pe;
    reset_dut();
    Pselx = SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b0;
    Penable = 1'b1;
    @(negedge clk);
    tests_run++;
    if (Prdata !== 32'd0) begin tests_failed++; $display("FAIL rstmid_prdata got %h exp %h", Prdata, 32'd0); end
    tests_run++;
    if (perr !== 1'b0) begin tests_failed++; $display("FAIL rstmid_perr got %b exp 0", perr); end
    rst_n = 1'b1;
    xfer(1'b0, 32'h08, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL rstmid_reg2 got %h exp %h", rd, 32'd0); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd0) begin tests_failed++; $display("FAIL rstmid_reg14 got %h exp %h", rd, 32'd0); end
    go_idle();
  endtask

  task automatic test_other_slave();
    logic [31:0] rd; logic pe;
    reset_dut();
    xfer(1'b1, 32'h10, 32'h77, rd, pe);
    go_idle();
    for (int i = 0; i < 6; i++) begin
      Pselx = OTHER; Penable = i[0]; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      tests_run++;
      if (perr !== 1'b0 || Prdata !== 32'd0) begin
        tests_failed++;
        $display("FAIL other_cycle%0d got perr=%b prdata=%h exp perr=0 prdata=0", i, perr, Prdata);
      end
    end
    go_idle();
    xfer(1'b0, 32'h10, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'h77) begin tests_failed++; $display("FAIL other_reg4 got %h exp %h", rd, 32'h77); end
    xfer(1'b0, 32'h38, 32'h0, rd, pe);
    tests_run++;
    if (rd !== 32'd1) begin tests_failed++; $display("FAIL other_reg14 got %h exp %h", rd, 32'd1); end
    go_idle();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'd0; Pwdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_penable_hold();
    test_range();
    test_proto_err();
    test_reset_mid();
    test_other_slave();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 SHALL provide parameter SLV_IDX, default 0, index of the Pselx bit that selects this slave (0..2).
REQ-002 SHALL provide port Hclk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port Hresetn  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port Pselx  input  3  one-hot APB select; slave selected when Pselx[SLV_IDX]=1 (psel).
REQ-005 SHALL provide port Penable  input  1  APB access-phase strobe.
REQ-006 SHALL provide port Pwrite  input  1  1=write, 0=read.
REQ-007 SHALL provide port Paddr  input  32  byte address; Paddr[5:2]=register index, Paddr[11:6] must be 0, Paddr[1:0] and [31:12] ignored.
REQ-008 SHALL provide port Pwdata  input  32  write data.
REQ-009 SHALL provide port Prdata  output  32  registered read data.
REQ-010 SHALL provide port perr  output  1  one-cycle protocol/range error pulse.

Function
REQ-011 SHALL track the APB phase with a 3-state FSM: IDLE, SETUP, ACCESS.
REQ-012 SHALL move IDLE->SETUP on psel & !Penable; IDLE with psel & Penable -> stays IDLE, perr=1 next cycle.
REQ-013 SHALL move SETUP->ACCESS on psel & Penable; any other input in SETUP -> IDLE, perr=1, no register access.
REQ-014 SHALL move ACCESS->SETUP on psel & !Penable (back-to-back), ACCESS->IDLE on !psel; psel & Penable in ACCESS (Penable held >1 cycle) -> IDLE, perr=1, no second access.
REQ-015 SHALL hold 16 x 32-bit registers: 0..13 read/write, 14 = write counter (RO, 16-bit, zero-extended, saturates at 0xFFFF), 15 = error counter (8-bit, zero-extended, saturates at 0xFF).
REQ-016 SHALL commit a write on the SETUP->ACCESS edge (psel & Penable & Pwrite in SETUP), Pwdata/Paddr sampled that cycle; new value readable from the next transfer.
REQ-017 SHALL increment the write counter by 1 per committed write to registers 0..13 only.
REQ-018 SHALL ignore writes to register 14; any write to register 15 SHALL clear the error counter.
REQ-019 SHALL load Prdata on IDLE/ACCESS->SETUP with a read (psel & !Penable & !Pwrite) so Prdata is valid throughout the ACCESS cycle (zero wait states, no Pready).
REQ-020 SHALL return Prdata to 0 the cycle after ACCESS unless a new read SETUP reloads it.
REQ-021 SHALL treat Paddr[11:6]!=0 as out of range: write dropped, read returns 0xDEAD_BEEF, perr=1 in the ACCESS cycle, error counter +1.
REQ-022 SHALL increment the error counter once per perr pulse; a clear (write to reg 15) and an increment in the same cycle SHALL result in 0 (clear wins).
REQ-023 SHALL ignore all inputs while !psel in IDLE (no perr).

Reset
REQ-024 SHALL, when Hresetn=0 at a rising edge, set FSM=IDLE, Prdata=0, perr=0, registers 0..15=0, both counters=0.
REQ-025 SHALL abort any in-flight transfer on reset (no write commits in the reset cycle); first valid SETUP accepted the cycle after Hresetn returns to 1.

Configuration
REQ-026 SHALL, with macro APB_SLV_ERRCHK_EN defined, implement the protocol checks (REQ-012..014), range errors (REQ-021) and error counter.
REQ-027 SHALL, without APB_SLV_ERRCHK_EN, tie perr=0, read register 15 as 0, treat out-of-range addresses as aliases of Paddr[5:2], and follow IDLE->SETUP->ACCESS on psel/Penable without error transitions.

Verification
REQ-028 Write Paddr=0x8000_0008, Pwdata=0xA5A5_1234, then read 0x8000_0008 -> Prdata=0xA5A5_1234 in read ACCESS cycle, reg14=1, perr=0.
REQ-029 Back-to-back: write reg0=0x1, write reg1=0x2, read reg0, read reg1 with no IDLE between -> reads return 0x1, 0x2; reg14=2.
REQ-030 Penable held high 2 cycles during write to reg3 -> exactly one commit, perr pulses once, reg15=1; then write reg15 -> reg15=0.
REQ-031 Read Paddr=0x8000_0040 (out of range) -> Prdata=0xDEAD_BEEF, perr=1, reg15 +1; write same address -> no register changes.
REQ-032 Hresetn=0 during SETUP of a write to reg2=0xFFFF_FFFF -> reg2=0, Prdata=0, FSM IDLE; subsequent read reg2 -> 0.
REQ-033 Pselx[SLV_IDX]=0 with other bits set, Penable toggling -> no register change, perr=0, Prdata=0.
